// File: rtl/omsp_dbg_uart_host.sv
// omsp_dbg_uart_host: serial host that turns a command handshake into openMSP430 debug-UART frames.
module omsp_dbg_uart_host #(
  parameter int CLK_DIV = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        dco_clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_byte8,
  input  logic [5:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_rdata,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        sync_done
);
  localparam int TO_CNT = TIMEOUT * CLK_DIV;
  localparam int TW = $clog2(TO_CNT + 1);
  localparam logic [7:0] TMAX = 8'(CLK_DIV - 1);
  localparam logic [7:0] HALF = 8'(CLK_DIV / 2 - 1);
  typedef enum logic [2:0] {SYNC, IDLE, TX_CMD, TX_LO, TX_HI, RX_LO, RX_HI, DONE} state_t;
  state_t      r_state;
  logic        r_wr, r_b8, r_ready, r_sync_done, r_rsp_valid, r_rsp_err;
  logic [5:0]  r_addr;
  logic [15:0] r_wdata, r_rsp_rdata;
  logic        r_tx_act, r_txd, r_rx_act;
  logic [7:0]  r_tx_tmr, r_rx_tmr, r_rx_sh, r_lo;
  logic [3:0]  r_tx_idx, r_rx_idx;
  logic [8:0]  r_tx_sh;
  logic [2:0]  r_rx_s;
  logic [TW-1:0] r_to;
  logic        w_rx, w_rx_fall, w_in_rx, w_tx_end, w_rx_end, w_to, w_ld;
  logic [7:0]  w_ld_byte;
  // r_rx_s[1:0] is the synchroniser; r_rx_s[2] is the previous synchronised level for edge detection
  assign w_rx      = r_rx_s[1];
  assign w_rx_fall = r_rx_s[2] & ~r_rx_s[1];
  assign w_in_rx   = (r_state == RX_LO) || (r_state == RX_HI);
  assign w_tx_end  = r_tx_act && (r_tx_tmr == 8'd0) && (r_tx_idx == 4'd9);
  assign w_rx_end  = r_rx_act && (r_rx_tmr == 8'd0) && (r_rx_idx == 4'd9);
  assign w_to      = w_in_rx && !r_rx_act && (r_to == TW'(TO_CNT - 1));
  // a follow-on frame is loaded on the same edge the previous stop bit ends, keeping frames back-to-back
  assign w_ld = (!r_tx_act && (r_state == SYNC || r_state == TX_CMD)) ||
                (w_tx_end && ((r_state == TX_CMD && r_wr) || (r_state == TX_LO && !r_b8)));
  assign w_ld_byte = (r_state == SYNC) ? 8'h80 :
                     (r_state == TX_CMD && !r_tx_act) ? {r_wr, r_b8, r_addr} :
                     (r_state == TX_CMD) ? r_wdata[7:0] : r_wdata[15:8];
  assign uart_txd  = r_txd;
  assign cmd_ready = r_ready;
  assign sync_done = r_sync_done;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SYNC;
      r_wr <= 1'b0;
      r_b8 <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_sync_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
      r_tx_act <= 1'b0;
      r_txd <= 1'b1;
      r_tx_tmr <= '0;
      r_tx_idx <= '0;
      r_tx_sh <= '1;
      r_rx_s <= 3'b111;
      r_rx_act <= 1'b0;
      r_rx_tmr <= '0;
      r_rx_idx <= '0;
      r_rx_sh <= '0;
      r_lo <= '0;
      r_to <= '0;
    end else begin
      r_rx_s <= {r_rx_s[1:0], uart_rxd};
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
      if (w_ld) begin
        r_tx_act <= 1'b1;
        r_txd <= 1'b0;
        r_tx_sh <= {1'b1, w_ld_byte};
        r_tx_idx <= '0;
        r_tx_tmr <= TMAX;
      end else if (w_tx_end) begin
        r_tx_act <= 1'b0;
      end else if (r_tx_act && r_tx_tmr == 8'd0) begin
        r_txd <= r_tx_sh[0];
        r_tx_sh <= {1'b1, r_tx_sh[8:1]};
        r_tx_idx <= r_tx_idx + 4'd1;
        r_tx_tmr <= TMAX;
      end else if (r_tx_act) begin
        r_tx_tmr <= r_tx_tmr - 8'd1;
      end
      // index 0 is the half-bit start confirmation, 1..8 data, 9 stop
      if (!w_in_rx || w_rx_end) begin
        r_rx_act <= 1'b0;
      end else if (!r_rx_act) begin
        r_rx_act <= w_rx_fall;
        r_rx_tmr <= HALF;
        r_rx_idx <= '0;
      end else if (r_rx_tmr != 8'd0) begin
        r_rx_tmr <= r_rx_tmr - 8'd1;
      end else if (r_rx_idx == 4'd0 && w_rx) begin
        r_rx_act <= 1'b0;
      end else begin
        r_rx_sh <= (r_rx_idx == 4'd0) ? r_rx_sh : {w_rx, r_rx_sh[7:1]};
        r_rx_idx <= r_rx_idx + 4'd1;
        r_rx_tmr <= TMAX;
      end
      r_to <= (!w_in_rx || r_rx_act) ? '0 : (r_to == TW'(TO_CNT)) ? r_to : r_to + TW'(1);
      case (r_state)
        SYNC: if (w_tx_end) begin
          r_state <= IDLE;
          r_sync_done <= 1'b1;
          r_ready <= 1'b1;
        end
        IDLE: if (cmd_valid) begin
          r_wr <= cmd_write;
          r_b8 <= cmd_byte8;
          r_addr <= cmd_addr;
          r_wdata <= cmd_wdata;
          r_ready <= 1'b0;
          r_state <= TX_CMD;
        end
        TX_CMD: if (w_tx_end) r_state <= r_wr ? TX_LO : RX_LO;
        TX_LO, TX_HI: if (w_tx_end) begin
          r_state <= (r_state == TX_LO && !r_b8) ? TX_HI : DONE;
          r_rsp_valid <= (r_state == TX_HI) || r_b8;
        end
        RX_LO, RX_HI: if (w_to || (w_rx_end && !w_rx)) begin
          r_state <= DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_err <= 1'b1;
        end else if (w_rx_end && r_state == RX_LO && !r_b8) begin
          r_lo <= r_rx_sh;
          r_state <= RX_HI;
        end else if (w_rx_end) begin
          r_state <= DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= (r_state == RX_LO) ? {8'h00, r_rx_sh} : {r_rx_sh, r_lo};
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= SYNC;
      endcase
    end
  end
endmodule

// File: doc/omsp_dbg_uart_host.md
# omsp_dbg_uart_host

Serial host for the openMSP430 debug UART. It drives the target's `dbg_uart_rxd` line and receives the target's `dbg_uart_txd` line. A simple command handshake is turned into debug-protocol frames:
- a synchronisation frame after reset;
- then a command byte, followed by write data or read data.

It sits in the simulation/FPGA harness beside `openMSP430`, replacing the constant tie-off on `dbg_uart_rxd`, so that debug register accesses can be issued while the CPU runs.

## Interface
Parameters:
- `CLK_DIV`, default 16: `dco_clk` cycles per UART bit; legal range 4..255.
- `TIMEOUT`, default 64: bit periods to wait for a read-reply start bit before an error response.

Ports:
- `dco_clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  host idle and synced; command accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_byte8`  in  1  1 = 8-bit access, 0 = 16-bit.
- `cmd_addr`  in  6  debug register address.
- `cmd_wdata`  in  16  write data; `[7:0]` only when `cmd_byte8`.
- `rsp_valid`  out  1  one-cycle pulse at command completion.
- `rsp_err`  out  1  qualified by `rsp_valid`; set on read timeout or framing error.
- `rsp_rdata`  out  16  read data, zero-extended for 8-bit; 0 for writes or errors.
- `uart_txd`  out  1  serial out, connects to the target's `dbg_uart_rxd`.
- `uart_rxd`  in  1  serial in from the target's `dbg_uart_txd`; asynchronous.
- `sync_done`  out  1  sync frame has been sent.

## Operation
- **Frame format:** 8N1, LSB first, idle high. Start bit 0, 8 data bits, stop bit 1; each bit lasts `CLK_DIV` cycles.
- **Command byte:** `{cmd_write, cmd_byte8, cmd_addr[5:0]}`.
- **Byte order:** data bytes go low byte first, then high byte (16-bit access only).
- **State machine:**
  - `SYNC` sends 0x80 once after reset, then goes to `IDLE` and sets `sync_done`.
  - `IDLE` holds `cmd_ready` = 1. On accept it latches all `cmd_*` fields and goes to `TX_CMD`.
  - `TX_CMD` goes to `TX_LO` when writing, or to `RX_LO` when reading.
  - `TX_LO` goes to `TX_HI` for a 16-bit write, or to `DONE` for an 8-bit write.
  - `TX_HI` goes to `DONE`.
  - `RX_LO` goes to `RX_HI` for a 16-bit read, or to `DONE` for an 8-bit read.
  - `RX_HI` goes to `DONE`.
  - `DONE` pulses `rsp_valid` for 1 cycle, then returns to `IDLE`.
- **Receiver:**
  - `uart_rxd` passes through a 2-flop synchroniser.
  - Start is detected on a synchronised falling edge; it is confirmed low at half-bit (`CLK_DIV/2` cycles).
  - Data bits are sampled at bit centres.
  - If the stop bit samples 0, the error is latched and `DONE` is entered immediately with `rsp_err` = 1.
  - The receiver is active only in `RX_LO` and `RX_HI`; line activity in any other state is ignored.
- **Timeout:** in `RX_LO` or `RX_HI`, a counter runs from state entry until a start bit is detected. On reaching `TIMEOUT*CLK_DIV` cycles, the block goes to `DONE` with `rsp_err` = 1 and `rsp_rdata` = 0.
- **Counters:**
  - The bit-timer counts `CLK_DIV-1` down to 0.
  - The bit index is 4 bits wide (0..9).
  - The timeout counter saturates and does not wrap.
- **Input rules:**
  - `cmd_*` changes are ignored while `cmd_ready` = 0.
  - `cmd_valid` high during `SYNC` waits; it is not dropped.
- **Reset mid-operation:** all state is cleared and the current frame is truncated; `uart_txd` returns high immediately. `SYNC` is resent after reset.

## Timing
Reset values:
- `uart_txd` = 1, `cmd_ready` = 0, `rsp_valid` = 0.
- `rsp_err` = 0, `rsp_rdata` = 0, `sync_done` = 0.

Sync frame:
- Its start bit begins on the first clock edge after `reset_n` deasserts.
- `sync_done` and `cmd_ready` rise `10*CLK_DIV` cycles after that.

Commands:
- The command start bit drives `uart_txd` low on the cycle after the accept edge.
- TX frames are back-to-back, with no extra idle bits.
- `cmd_ready` drops on the accept edge. It returns high on the cycle after the `rsp_valid` pulse.

Latencies, accept to `rsp_valid`:
- 8-bit write: `20*CLK_DIV + 1` cycles.
- 16-bit write: `30*CLK_DIV + 1` cycles.
- Read: `rsp_valid` comes 1 cycle after the final stop-bit sample, i.e. the centre of the last stop bit.
- Read data is also reported as `rsp_rdata` on that same cycle.

## Test plan
- **Sync:** release reset with `CLK_DIV`=16. Required: `uart_txd` low for 16 cycles, then pattern 0,0,0,0,0,0,0,1 (LSB first) at bit centres, then stop 1. `sync_done` = 1 at cycle 160.
- **16-bit write:** addr 0x01, data 0xA55A. Required: bytes 0x81, 0x5A, 0xA5 on `uart_txd`; `rsp_valid` at 481 cycles after accept with `rsp_err` = 0.
- **8-bit read:** addr 0x02. Required: byte 0x42 sent. Then the bench drives reply 0x3C at 16 cycles/bit; required `rsp_rdata` = 0x003C and `rsp_err` = 0.
- **16-bit read:** addr 0x00. Required: byte 0x00 sent. Then the bench replies 0x34, 0x12; required `rsp_rdata` = 0x1234.
- **Read timeout:** bench never replies. Required: `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` = 0 after 64*16 cycles in `RX_LO`; `cmd_ready` is high on the next cycle.
- **Framing error and reset:**
  - Bench replies with stop bit 0. Required: `rsp_err` = 1.
  - Assert `reset_n` low mid-TX. Required: `uart_txd` = 1 asynchronously, and `SYNC` is resent after release.
